// File: rtl/mem_req_arbiter_if.sv
// Shared data-memory port bundle and the memory operation type.
// CPU modport drives the request side; MEM modport is the memory.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package mem_req_arbiter_pkg;
  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_op_t;
endpackage

interface MEM_IF;
  import mem_req_arbiter_pkg::*;

  logic                            memory_req_valid;
  memory_op_t                      memory_req_op;
  logic [`D_MEMORY_ADDR_WIDTH-1:0] memory_req_address;
  logic [`REG_VAL_WIDTH-1:0]       memory_req_data;
  logic                            memory_ready;
  logic                            memory_ack;
  logic [`REG_VAL_WIDTH-1:0]       memory_data_return;

  modport CPU (
    output memory_req_valid,
    output memory_req_op,
    output memory_req_address,
    output memory_req_data,
    input  memory_ready,
    input  memory_ack,
    input  memory_data_return
  );

  modport MEM (
    input  memory_req_valid,
    input  memory_req_op,
    input  memory_req_address,
    input  memory_req_data,
    output memory_ready,
    output memory_ack,
    output memory_data_return
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one outstanding
// transaction at a time on the shared data-memory port.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  memory_op_t                      req_op      [NUM_REQ],
  input  logic [`D_MEMORY_ADDR_WIDTH-1:0] req_address [NUM_REQ],
  input  logic [`REG_VAL_WIDTH-1:0]       req_data    [NUM_REQ],
  output logic [NUM_REQ-1:0]              req_grant,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [`REG_VAL_WIDTH-1:0]       resp_data,
  output logic                            resp_timeout,
  output logic                            busy,
  MEM_IF.CPU                              mem
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]                      state;
  logic [PW-1:0]                   rr_ptr;
  logic [PW-1:0]                   owner;
  logic [CW-1:0]                   cnt;
  memory_op_t                      hold_op;
  logic [`D_MEMORY_ADDR_WIDTH-1:0] hold_addr;
  logic [`REG_VAL_WIDTH-1:0]       hold_data;

  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;
  logic          take;
  logic          tmo_hit;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign take = rst_n && (state == IDLE) && found;

  always_comb begin
    req_grant = '0;
    if (take) req_grant[win] = 1'b1;
  end

  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  assign busy                   = (state != IDLE);
  assign mem.memory_req_valid   = (state == ISSUE);
  assign mem.memory_req_op      = hold_op;
  assign mem.memory_req_address = hold_addr;
  assign mem.memory_req_data    = hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      cnt          <= '0;
      hold_op      <= MEM_LOAD;
      hold_addr    <= '0;
      hold_data    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      resp_valid   <= '0;
      resp_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            owner     <= win;
            hold_op   <= req_op[win];
            hold_addr <= req_address[win];
            hold_data <= req_data[win];
            rr_ptr    <= (win == PW'(NUM_REQ - 1)) ?
                         '0 : win + 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem.memory_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem.memory_ack) begin
            resp_valid[owner] <= 1'b1;
            resp_data         <= mem.memory_data_return;
            state             <= IDLE;
          end else if (tmo_hit) begin
            resp_valid[owner] <= 1'b1;
            resp_timeout      <= 1'b1;
            resp_data         <= '0;
            state             <= IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: load, fairness, backpressure,
// timeout, reset mid-transaction and back-to-back grant.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b1;
  logic [1:0]                      rv;
  memory_op_t                      rop   [2];
  logic [`D_MEMORY_ADDR_WIDTH-1:0] raddr [2];
  logic [`REG_VAL_WIDTH-1:0]       rdata [2];
  logic [1:0]                      grant;
  logic [1:0]                      rsp;
  logic [`REG_VAL_WIDTH-1:0]       rsp_data;
  logic                            rsp_tmo;
  logic                            busy;

  int total = 0;
  int bad   = 0;
  int exp_w;
  int prev_w;

  MEM_IF mif ();

  mem_req_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (rv),
    .req_op       (rop),
    .req_address  (raddr),
    .req_data     (rdata),
    .req_grant    (grant),
    .resp_valid   (rsp),
    .resp_data    (rsp_data),
    .resp_timeout (rsp_tmo),
    .busy         (busy),
    .mem          (mif.CPU)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rv = 2'b00;
    rop[0] = MEM_LOAD;  rop[1] = MEM_LOAD;
    raddr[0] = '0;      raddr[1] = '0;
    rdata[0] = '0;      rdata[1] = '0;
    mif.memory_ready       = 1'b0;
    mif.memory_ack         = 1'b0;
    mif.memory_data_return = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_resp", 64'(rsp), 64'd0);
    chk("rst_rdata", 64'(rsp_data), 64'd0);
    chk("rst_tmo", 64'(rsp_tmo), 64'd0);
    chk("rst_mvalid", 64'(mif.memory_req_valid), 64'd0);
    chk("rst_mop", 64'(mif.memory_req_op), 64'd0);
    chk("rst_maddr", 64'(mif.memory_req_address), 64'd0);
    chk("rst_mdata", 64'(mif.memory_req_data), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // single load
    cyc();
    rv = 2'b01; rop[0] = MEM_LOAD; raddr[0] = 32'h40;
    mif.memory_ready = 1'b1;
    #1 chk("ld_grant", 64'(grant), 64'h1);
    cyc();
    rv = 2'b00; raddr[0] = 32'h0;
    #1;
    chk("ld_mvalid", 64'(mif.memory_req_valid), 64'd1);
    chk("ld_maddr", 64'(mif.memory_req_address), 64'h40);
    chk("ld_mop", 64'(mif.memory_req_op), 64'(MEM_LOAD));
    cyc();
    #1;
    chk("ld_wait_mvalid", 64'(mif.memory_req_valid), 64'd0);
    chk("ld_wait_busy", 64'(busy), 64'd1);
    cyc();
    mif.memory_ack = 1'b1;
    mif.memory_data_return = 32'hDEADBEEF;
    cyc();
    mif.memory_ack = 1'b0;
    #1;
    chk("ld_resp", 64'(rsp), 64'h1);
    chk("ld_rdata", 64'(rsp_data), 64'hDEADBEEF);
    chk("ld_tmo", 64'(rsp_tmo), 64'd0);
    cyc();
    #1;
    chk("ld_resp_pulse", 64'(rsp), 64'd0);
    chk("ld_idle", 64'(busy), 64'd0);

    // fairness: rr_ptr points at 1 after the load above
    rv = 2'b11;
    exp_w = 1;
    prev_w = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", 64'(grant), 64'(1 << exp_w));
      if (k > 0) chk("rr_resp", 64'(rsp), 64'(1 << prev_w));
      cyc();
      #1 chk("rr_mvalid", 64'(mif.memory_req_valid), 64'd1);
      cyc();
      mif.memory_ack = 1'b1;
      mif.memory_data_return = 32'(k);
      cyc();
      mif.memory_ack = 1'b0;
      if (k == 7) rv = 2'b00;
      prev_w = exp_w;
      exp_w = 1 - exp_w;
    end
    #1;
    chk("rr_resp_last", 64'(rsp), 64'(1 << prev_w));
    chk("rr_rdata_last", 64'(rsp_data), 64'd7);

    // backpressure store; lone requester 0 wins with rr_ptr at 1
    cyc();
    rv = 2'b01; rop[0] = MEM_STORE;
    raddr[0] = 32'h80; rdata[0] = 32'h1234;
    mif.memory_ready = 1'b0;
    #1 chk("st_grant", 64'(grant), 64'h1);
    cyc();
    rv = 2'b00; rop[0] = MEM_LOAD;
    raddr[0] = 32'hFFF; rdata[0] = 32'h5555;
    for (int i = 0; i < 6; i++) begin
      mif.memory_ready = (i == 5);
      #1;
      chk("st_mvalid", 64'(mif.memory_req_valid), 64'd1);
      chk("st_mop", 64'(mif.memory_req_op), 64'(MEM_STORE));
      chk("st_maddr", 64'(mif.memory_req_address), 64'h80);
      chk("st_mdata", 64'(mif.memory_req_data), 64'h1234);
      cyc();
    end
    mif.memory_ready = 1'b1;
    #1 chk("st_wait_mvalid", 64'(mif.memory_req_valid), 64'd0);
    mif.memory_ack = 1'b1;
    mif.memory_data_return = 32'h55;
    cyc();
    mif.memory_ack = 1'b0;
    #1;
    chk("st_resp", 64'(rsp), 64'h1);
    chk("st_rdata", 64'(rsp_data), 64'h55);
    chk("st_tmo", 64'(rsp_tmo), 64'd0);

    // timeout on requester 1
    cyc();
    rv = 2'b10; raddr[1] = 32'h100;
    #1 chk("to_grant", 64'(grant), 64'h2);
    cyc();
    rv = 2'b00;
    cyc();
    for (int j = 0; j < 16; j++) begin
      #1;
      chk("to_quiet", 64'(rsp), 64'd0);
      chk("to_busy", 64'(busy), 64'd1);
      cyc();
    end
    #1;
    chk("to_resp", 64'(rsp), 64'h2);
    chk("to_flag", 64'(rsp_tmo), 64'd1);
    chk("to_rdata", 64'(rsp_data), 64'd0);
    cyc();
    mif.memory_ack = 1'b1;
    mif.memory_data_return = 32'hABC;
    #1 chk("to_late_busy", 64'(busy), 64'd0);
    cyc();
    mif.memory_ack = 1'b0;
    #1;
    chk("to_late_resp", 64'(rsp), 64'd0);
    chk("to_late_tmo", 64'(rsp_tmo), 64'd0);

    // next request; ack on the last WAIT cycle before expiry
    rv = 2'b01; raddr[0] = 32'h200;
    #1 chk("lim_grant", 64'(grant), 64'h1);
    cyc();
    rv = 2'b00;
    cyc();
    repeat (15) cyc();
    mif.memory_ack = 1'b1;
    mif.memory_data_return = 32'h77;
    cyc();
    mif.memory_ack = 1'b0;
    #1;
    chk("lim_resp", 64'(rsp), 64'h1);
    chk("lim_tmo", 64'(rsp_tmo), 64'd0);
    chk("lim_rdata", 64'(rsp_data), 64'h77);

    // reset during WAIT
    cyc();
    rv = 2'b10; raddr[1] = 32'h300;
    #1 chk("rw_grant", 64'(grant), 64'h2);
    cyc();
    rv = 2'b11;
    cyc();
    mif.memory_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_grant0", 64'(grant), 64'd0);
    chk("rw_resp", 64'(rsp), 64'd0);
    chk("rw_mvalid", 64'(mif.memory_req_valid), 64'd0);
    chk("rw_maddr", 64'(mif.memory_req_address), 64'd0);
    cyc();
    rv = 2'b00;
    mif.memory_ack = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rw_no_resp", 64'(rsp), 64'd0);
      chk("rw_idle", 64'(busy), 64'd0);
      cyc();
    end
    mif.memory_ack = 1'b0;
    rv = 2'b11; raddr[0] = 32'h400; raddr[1] = 32'h500;
    #1 chk("rw_first", 64'(grant), 64'h1);

    // back-to-back: grant 1 in the cycle resp_valid[0] fires
    cyc();
    rv = 2'b00;
    cyc();
    mif.memory_ack = 1'b1;
    mif.memory_data_return = 32'h99;
    cyc();
    mif.memory_ack = 1'b0;
    rv = 2'b10;
    #1;
    chk("bb_resp0", 64'(rsp), 64'h1);
    chk("bb_rdata", 64'(rsp_data), 64'h99);
    chk("bb_grant1", 64'(grant), 64'h2);
    cyc();
    rv = 2'b00;
    #1;
    chk("bb_mvalid", 64'(mif.memory_req_valid), 64'd1);
    chk("bb_maddr", 64'(mif.memory_req_address), 64'h500);
    cyc();
    mif.memory_ack = 1'b1;
    mif.memory_data_return = 32'h11;
    cyc();
    mif.memory_ack = 1'b0;
    #1;
    chk("bb_resp1", 64'(rsp), 64'h2);
    chk("bb_rdata1", 64'(rsp_data), 64'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
